layer_compositor_pipe: RTL
==========================

// Module: layer_compositor_pipe
// PURPOSE
//   Parametrised, pipelined N-layer priority compositor that replaces the fixed if/else pixel mux in the gfx top level.
//   Each layer generator (penguin, coins, barriers, HUD digits, clouds...) supplies a hit flag and RGB. The block selects
//   the highest-priority visible layer per pixel and registers RGB plus aligned x/y/de. It also latches per-frame
//   overlaps between the player layer and every other layer, for the game FSM (coin/barrier hit detection).
// PARAMETERS
//   N_LAYERS    16        number of input layers; index 0 = highest priority
//   COLOR_W     8         bits per colour channel
//   COORD_W     16        width of i_x / i_y
//   PIPE_STAGES 2         output latency in cycles; legal values 1 or 2
//   KEY_EN      1         1 = layer pixels equal to KEY_RGB are treated as transparent
//   KEY_RGB     24'hFF00FF transparent colour key {r,g,b}; applies when COLOR_W==8
//   PLAYER_IDX  0         layer index used as collision reference
// PORTS
//   i_clk         in   1                 pixel clock
//   i_rst_n       in   1                 reset, asynchronous assert, active low
//   i_x           in   COORD_W           current pixel x
//   i_y           in   COORD_W           current pixel y
//   i_de          in   1                 active-video qualifier for this pixel
//   i_v_sync      in   1                 frame sync; rising edge closes a frame
//   i_layer_en    in   N_LAYERS          per-layer enable mask
//   i_layer_hit   in   N_LAYERS          per-layer hit flags
//   i_layer_rgb   in   N_LAYERS*3*COLOR_W packed {r,g,b} per layer; layer k at bits [k*3*COLOR_W +: 3*COLOR_W]
//   i_bg_rgb      in   3*COLOR_W         background colour when no layer wins
//   o_red/o_green/o_blue out COLOR_W     composited colour
//   o_de          out  1                 i_de delayed by PIPE_STAGES
//   o_x, o_y      out  COORD_W           i_x / i_y delayed by PIPE_STAGES
//   o_layer_id    out  $clog2(N_LAYERS+1) winning layer; N_LAYERS = background
//   o_coll_flags  out  N_LAYERS          layers that overlapped PLAYER_IDX during the last closed frame
//   o_coll_pulse  out  1                 one-cycle pulse at frame close when any o_coll_flags bit is set
//   o_frame_cnt   out  16                closed-frame counter
// BEHAVIOUR
//   - Reset (async, i_rst_n=0): every output, pipeline register, accumulator and sync-edge register goes to 0.
//     Release is synchronous to i_clk.
//   - Visibility: vis[k] = i_layer_hit[k] & i_layer_en[k] & ~(KEY_EN && rgb[k]==KEY_RGB).
//   - Selection: lowest k with vis[k]=1 wins; if none, i_bg_rgb and id=N_LAYERS.
//   - Stage 1 registers colour, id, x, y and de. When PIPE_STAGES==2, stage 2 re-registers all of them.
//     Latency is exactly PIPE_STAGES cycles, with all outputs aligned. Throughput is 1 pixel per clock, no stalls.
//   - Blanking: when the delayed de is 0, o_red/o_green/o_blue are 0. o_layer_id and o_x/o_y still follow the pipeline.
//   - Collision accumulate: each cycle with i_de=1 and vis[PLAYER_IDX]=1,
//     acc[k] |= vis[k] for k!=PLAYER_IDX. acc[PLAYER_IDX] is always 0.
//   - Frame close:
//     - Detected on the rising edge of registered i_v_sync (vs_q=0, i_v_sync=1).
//     - That cycle: o_coll_flags <= acc | this-cycle hits, acc <= 0.
//     - o_coll_pulse <= |(new flags); it falls next cycle.
//     - o_frame_cnt increments, wrapping 16'hFFFF -> 0.
//     - A collision in the same cycle as the edge belongs to the closing frame.
//   - o_coll_flags holds until the next frame close. A level-high i_v_sync does not re-close a frame.
//   - PLAYER_IDX disabled through i_layer_en: no collisions accumulate; the frame still closes with flags 0.
//   - Reset mid-frame discards acc. The first edge after reset reports only hits since reset.
//   - Illegal PIPE_STAGES (not 1/2) or PLAYER_IDX>=N_LAYERS: elaboration $error.
// TESTING
//   1 Reset: hold i_rst_n=0 with random inputs -> all outputs 0. Release, drive hit[3]=1 rgb=24'h112233, de=1
//     -> o_* = 11/22/33, o_layer_id=3 exactly 2 cycles later.
//   2 Priority/enable: hit[2]=hit[5]=1 -> id 2. Clear en[2] -> id 5. Clear all hits -> bg rgb, id=16.
//   3 Colour key: hit[1]=1 rgb=FF00FF, hit[4]=1 rgb=00FF00 -> output 00FF00, id 4. With KEY_EN=0 -> FF00FF, id 1.
//   4 Blanking: de=0 with hit[0]=1 -> rgb 0, o_de=0, o_x/o_y still delayed by 2.
//   5 Collision: hit[0]&hit[7] for 3 de cycles, then v_sync rise -> o_coll_flags=16'h0080, pulse exactly 1 cycle,
//     frame_cnt+1. Next frame with no overlap -> flags 0, no pulse.
//   6 Edge cases: overlap on the v_sync edge cycle lands in the closing frame. Hold v_sync high 10 cycles -> one close.
//     Async reset mid-frame -> flags and frame_cnt reset to 0.

Source files
------------

// File: rtl/layer_compositor_pipe.sv
// N-layer priority compositor: picks the highest-priority visible layer per pixel, pipelines RGB/x/y/de,
// and latches per-frame overlaps between the player layer and every other layer.
module layer_compositor_pipe #(
  parameter int          N_LAYERS    = 16,
  parameter int          COLOR_W     = 8,
  parameter int          COORD_W     = 16,
  parameter int          PIPE_STAGES = 2,
  parameter int          KEY_EN      = 1,
  parameter logic [23:0] KEY_RGB     = 24'hFF00FF,
  parameter int          PLAYER_IDX  = 0
) (
  input  logic                            i_clk,
  input  logic                            i_rst_n,
  input  logic [COORD_W-1:0]              i_x,
  input  logic [COORD_W-1:0]              i_y,
  input  logic                            i_de,
  input  logic                            i_v_sync,
  input  logic [N_LAYERS-1:0]             i_layer_en,
  input  logic [N_LAYERS-1:0]             i_layer_hit,
  input  logic [N_LAYERS*3*COLOR_W-1:0]   i_layer_rgb,
  input  logic [3*COLOR_W-1:0]            i_bg_rgb,
  output logic [COLOR_W-1:0]              o_red,
  output logic [COLOR_W-1:0]              o_green,
  output logic [COLOR_W-1:0]              o_blue,
  output logic                            o_de,
  output logic [COORD_W-1:0]              o_x,
  output logic [COORD_W-1:0]              o_y,
  output logic [$clog2(N_LAYERS+1)-1:0]   o_layer_id,
  output logic [N_LAYERS-1:0]             o_coll_flags,
  output logic                            o_coll_pulse,
  output logic [15:0]                     o_frame_cnt
);
  localparam int RGB_W = 3 * COLOR_W;
  localparam int ID_W  = $clog2(N_LAYERS + 1);
  // The colour key is only meaningful for 8-bit channels.
  localparam bit               KEY_ON      = (KEY_EN != 0) && (COLOR_W == 8);
  localparam logic [RGB_W-1:0] KEY_CMP     = RGB_W'(KEY_RGB);
  localparam logic [N_LAYERS-1:0] PLAYER_MASK = N_LAYERS'(1) << PLAYER_IDX;

  generate
    if (PIPE_STAGES != 1 && PIPE_STAGES != 2) begin : g_bad_pipe
      $error("layer_compositor_pipe: PIPE_STAGES must be 1 or 2");
    end
    if (PLAYER_IDX < 0 || PLAYER_IDX >= N_LAYERS) begin : g_bad_player
      $error("layer_compositor_pipe: PLAYER_IDX out of range");
    end
  endgenerate

  logic [N_LAYERS-1:0] vis;

  generate
    for (genvar gi = 0; gi < N_LAYERS; gi++) begin : g_vis
      logic [RGB_W-1:0] px;
      assign px      = i_layer_rgb[gi*RGB_W +: RGB_W];
      assign vis[gi] = i_layer_hit[gi] & i_layer_en[gi] & ~(KEY_ON && (px == KEY_CMP));
    end
  endgenerate

  logic [RGB_W-1:0] sel_rgb;
  logic [ID_W-1:0]  sel_id;

  // Scan from lowest priority upwards so the lowest visible index overwrites last.
  always_comb begin
    sel_rgb = i_bg_rgb;
    sel_id  = ID_W'(N_LAYERS);
    for (int k = N_LAYERS - 1; k >= 0; k--) begin
      if (vis[k]) begin
        sel_rgb = i_layer_rgb[k*RGB_W +: RGB_W];
        sel_id  = ID_W'(k);
      end
    end
  end

  logic [RGB_W-1:0]   s1_rgb_d, s1_rgb_q;
  logic [ID_W-1:0]    s1_id_q;
  logic [COORD_W-1:0] s1_x_q, s1_y_q;
  logic               s1_de_q;

  assign s1_rgb_d = i_de ? sel_rgb : '0;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      s1_rgb_q <= '0;
      s1_id_q  <= '0;
      s1_x_q   <= '0;
      s1_y_q   <= '0;
      s1_de_q  <= 1'b0;
    end else begin
      s1_rgb_q <= s1_rgb_d;
      s1_id_q  <= sel_id;
      s1_x_q   <= i_x;
      s1_y_q   <= i_y;
      s1_de_q  <= i_de;
    end
  end

  logic [RGB_W-1:0]   out_rgb;
  logic [ID_W-1:0]    out_id;
  logic [COORD_W-1:0] out_x, out_y;
  logic               out_de;

  generate
    if (PIPE_STAGES == 2) begin : g_stage2
      logic [RGB_W-1:0]   s2_rgb_q;
      logic [ID_W-1:0]    s2_id_q;
      logic [COORD_W-1:0] s2_x_q, s2_y_q;
      logic               s2_de_q;

      always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
          s2_rgb_q <= '0;
          s2_id_q  <= '0;
          s2_x_q   <= '0;
          s2_y_q   <= '0;
          s2_de_q  <= 1'b0;
        end else begin
          s2_rgb_q <= s1_rgb_q;
          s2_id_q  <= s1_id_q;
          s2_x_q   <= s1_x_q;
          s2_y_q   <= s1_y_q;
          s2_de_q  <= s1_de_q;
        end
      end

      assign out_rgb = s2_rgb_q;
      assign out_id  = s2_id_q;
      assign out_x   = s2_x_q;
      assign out_y   = s2_y_q;
      assign out_de  = s2_de_q;
    end else begin : g_stage1_only
      assign out_rgb = s1_rgb_q;
      assign out_id  = s1_id_q;
      assign out_x   = s1_x_q;
      assign out_y   = s1_y_q;
      assign out_de  = s1_de_q;
    end
  endgenerate

  assign o_red      = out_rgb[RGB_W-1 -: COLOR_W];
  assign o_green    = out_rgb[2*COLOR_W-1 -: COLOR_W];
  assign o_blue     = out_rgb[COLOR_W-1:0];
  assign o_layer_id = out_id;
  assign o_x        = out_x;
  assign o_y        = out_y;
  assign o_de       = out_de;

  logic [N_LAYERS-1:0] acc_q, flags_q, hits_now, flags_d;
  logic                vs_q, pulse_q, frame_close;
  logic [15:0]         frame_cnt_q;

  assign hits_now    = (i_de && vis[PLAYER_IDX]) ? (vis & ~PLAYER_MASK) : '0;
  // Hits in the closing cycle itself belong to the frame being closed.
  assign flags_d     = acc_q | hits_now;
  assign frame_close = i_v_sync & ~vs_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      acc_q       <= '0;
      flags_q     <= '0;
      vs_q        <= 1'b0;
      pulse_q     <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      vs_q <= i_v_sync;
      if (frame_close) begin
        acc_q       <= '0;
        flags_q     <= flags_d;
        pulse_q     <= |flags_d;
        frame_cnt_q <= frame_cnt_q + 16'd1;
      end else begin
        acc_q   <= flags_d;
        pulse_q <= 1'b0;
      end
    end
  end

  assign o_coll_flags = flags_q;
  assign o_coll_pulse = pulse_q;
  assign o_frame_cnt  = frame_cnt_q;
endmodule
